// File: rtl/spi_host_master.sv
// SPI mode-0 master, MSB first: one SS-low frame per transaction (command byte + len payload bytes).
// Push streams bytes from the tx buffer; pull shifts zeros out and writes returned MISO bytes to the rx buffer.
module spi_host_master #(
  parameter int AddrBits = 12,
  parameter int ClkDiv   = 4
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic                start,
  input  logic                op,
  input  logic                cont,
  input  logic [AddrBits:0]   len,
  output logic                busy,
  output logic                done,
  output logic [AddrBits-1:0] txMemAddr,
  input  logic [7:0]          txMemData,
  output logic [AddrBits-1:0] rcMemAddr,
  output logic [7:0]          rcMemData,
  output logic                rcMemWE,
  output logic                SPI_CLK,
  output logic                SPI_MOSI,
  input  logic                SPI_MISO,
  output logic                SPI_SS
);

  localparam int DW = $clog2(2 * ClkDiv) + 1;
  localparam logic [DW-1:0] HALF_LAST = DW'(ClkDiv - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(2 * ClkDiv - 1);

  typedef enum logic [2:0] {IDLE, SS_SETUP, SHIFT, SS_HOLD, GAP} state_t;

  state_t            state, state_nx;
  logic [DW-1:0]     div_cnt;
  logic              half;
  logic [2:0]        bit_cnt;
  logic [AddrBits:0] byte_cnt, len_q;
  logic              op_q;
  logic [7:0]        shreg;
  logic [6:0]        rxreg;
  logic              accept, phase_end, rise, fall, last_byte;

  always_comb begin
    state_nx  = state;
    phase_end = (div_cnt == HALF_LAST);
    done      = (state == GAP) && (div_cnt == GAP_LAST);
    // The done cycle behaves like IDLE so a held start chains frames back to back.
    accept    = start && ((state == IDLE) || done);
    rise      = (state == SHIFT) && !half && phase_end;
    fall      = (state == SHIFT) && half && phase_end;
    last_byte = (byte_cnt == len_q);
    busy      = (state != IDLE);
    SPI_SS    = !((state == SS_SETUP) || (state == SHIFT) || (state == SS_HOLD));
    SPI_CLK   = (state == SHIFT) && half;
    SPI_MOSI  = ((state == SS_SETUP) || (state == SHIFT)) ? shreg[7] : 1'b0;
    case (state)
      IDLE:     if (accept) state_nx = SS_SETUP;
      SS_SETUP: if (phase_end) state_nx = SHIFT;
      SHIFT:    if (fall && (bit_cnt == 3'd7) && last_byte) state_nx = SS_HOLD;
      SS_HOLD:  if (phase_end) state_nx = GAP;
      GAP:      if (done) state_nx = accept ? SS_SETUP : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      half      <= 1'b0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      len_q     <= '0;
      op_q      <= 1'b0;
      shreg     <= '0;
      rxreg     <= '0;
      txMemAddr <= '0;
      rcMemAddr <= '0;
      rcMemData <= '0;
      rcMemWE   <= 1'b0;
    end else begin
      state   <= state_nx;
      rcMemWE <= 1'b0;
      if ((state_nx != state) || (state == IDLE) || ((state == SHIFT) && phase_end))
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;

      if (accept) begin
        op_q      <= op;
        len_q     <= len;
        shreg     <= op ? 8'h03 : (cont ? 8'h02 : 8'h01);
        txMemAddr <= '0;
      end

      if ((state == SS_SETUP) && phase_end) begin
        half     <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end

      // MISO is taken on the edge that raises SPI_CLK, before the slave moves it.
      if (rise) begin
        half  <= 1'b1;
        rxreg <= {rxreg[5:0], SPI_MISO};
        if (op_q && (bit_cnt == 3'd7) && (byte_cnt != '0)) begin
          rcMemWE   <= 1'b1;
          rcMemAddr <= AddrBits'(byte_cnt - 1'b1);
          rcMemData <= {rxreg, SPI_MISO};
        end
      end

      if (fall) begin
        half    <= 1'b0;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt != 3'd7) begin
          shreg <= {shreg[6:0], 1'b0};
        end else if (last_byte) begin
          txMemAddr <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          shreg    <= op_q ? 8'h00 : txMemData;
          // Prefetch the next byte; hold on the final one so nothing past len is read.
          if ((byte_cnt + 1'b1) < len_q)
            txMemAddr <= AddrBits'(byte_cnt + 1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: two instances (ClkDiv=2/AddrBits=12 and ClkDiv=1/AddrBits=2)
// driven through a shared stimulus bus, checked against frame-level expectations.
module tb_spi_host_master;

  logic SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  logic        Reset = 1'b1;
  logic        start = 1'b0, op = 1'b0, cont = 1'b0, sel = 1'b0, miso = 1'b0;
  logic [12:0] len = '0;

  logic        busy0, done0, we0, clk0, mosi0, ss0;
  logic [11:0] ta0, ra0;
  logic [7:0]  rd0, td0;
  logic        busy1, done1, we1, clk1, mosi1, ss1;
  logic [1:0]  ta1, ra1;
  logic [7:0]  rd1, td1;

  logic [7:0]  tx_mem [0:4095];
  always @(posedge SysClk) begin
    td0 <= tx_mem[ta0];
    td1 <= tx_mem[{10'd0, ta1}];
  end

  spi_host_master #(.AddrBits(12), .ClkDiv(2)) u0 (
    .SysClk(SysClk), .Reset(Reset), .start(start && !sel), .op(op), .cont(cont), .len(len),
    .busy(busy0), .done(done0), .txMemAddr(ta0), .txMemData(td0),
    .rcMemAddr(ra0), .rcMemData(rd0), .rcMemWE(we0),
    .SPI_CLK(clk0), .SPI_MOSI(mosi0), .SPI_MISO(miso), .SPI_SS(ss0));

  spi_host_master #(.AddrBits(2), .ClkDiv(1)) u1 (
    .SysClk(SysClk), .Reset(Reset), .start(start && sel), .op(op), .cont(cont), .len(len[2:0]),
    .busy(busy1), .done(done1), .txMemAddr(ta1), .txMemData(td1),
    .rcMemAddr(ra1), .rcMemData(rd1), .rcMemWE(we1),
    .SPI_CLK(clk1), .SPI_MOSI(mosi1), .SPI_MISO(miso), .SPI_SS(ss1));

  logic        m_busy, m_done, m_we, m_clk, m_mosi, m_ss;
  logic [11:0] m_ta, m_ra;
  logic [7:0]  m_rd;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_we   = sel ? we1   : we0;
  assign m_clk  = sel ? clk1  : clk0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_ss   = sel ? ss1   : ss0;
  assign m_ta   = sel ? {10'd0, ta1} : ta0;
  assign m_ra   = sel ? {10'd0, ra1} : ra0;
  assign m_rd   = sel ? rd1 : rd0;

  int vec = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on instance s; the reference is the byte stream the frame must carry,
  // the slave's MISO byte stream, and the closed-form cycle counts.
  task automatic txn(input bit s, input bit o, input bit c, input int n,
                     input bit hold, input int abort_rise);
    int cd, aw, exp_busy, exp_ss, busy_cnt, ss_cnt, done_at, rises, f;
    logic prev_clk, prev_mosi, done_seen;
    logic [7:0] cur, tmp;
    logic [7:0] exp_b[$], got_b[$], mb[$], wd[$];
    int wa[$];
    cd = s ? 1 : 2;
    aw = s ? 2 : 12;
    exp_b.push_back(o ? 8'h03 : (c ? 8'h02 : 8'h01));
    mb.push_back(8'($urandom));
    for (int k = 0; k < n; k++) begin
      exp_b.push_back(o ? 8'h00 : tx_mem[k]);
      mb.push_back(8'($urandom));
    end
    exp_busy = cd * (20 + 16 * n);
    exp_ss   = cd * (18 + 16 * n);
    sel = s; op = o; cont = c; len = 13'(n); start = 1'b1;
    tmp = mb[0]; miso = tmp[7];
    prev_clk = m_clk; prev_mosi = m_mosi; cur = '0;
    rises = 0; busy_cnt = 0; ss_cnt = 0; done_at = 0;
    for (int cyc = 1; cyc <= exp_busy + 40; cyc++) begin
      @(posedge SysClk); @(negedge SysClk);
      if (cyc == 1 && !hold) start = 1'b0;
      if (m_busy) busy_cnt++;
      if (!m_ss) ss_cnt++;
      if (m_we) begin wa.push_back(int'(m_ra)); wd.push_back(m_rd); end
      if (m_clk && !prev_clk) begin
        chk("mosi_stable_at_rise", m_mosi, prev_mosi);
        if (!o && (rises % 8 == 0)) begin
          f = rises / 8;
          if (f == 0) chk("tx_addr_cmd", m_ta, 0);
          else if (f < n) chk("tx_addr_prefetch", m_ta, f);
        end
        cur = {cur[6:0], m_mosi};
        rises++;
        if (rises % 8 == 0) got_b.push_back(cur);
        if (rises / 8 < mb.size()) begin tmp = mb[rises / 8]; miso = tmp[7 - rises % 8]; end
        else miso = 1'b0;
      end
      prev_clk = m_clk; prev_mosi = m_mosi;
      if (abort_rise > 0 && rises == abort_rise) begin
        Reset = 1'b1;
        @(posedge SysClk); @(negedge SysClk);
        chk("abort_ss", m_ss, 1);
        chk("abort_clk", m_clk, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_done", m_done, 0);
        chk("abort_we", m_we, 0);
        Reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(posedge SysClk); @(negedge SysClk);
          if (m_we) begin wa.push_back(int'(m_ra)); wd.push_back(m_rd); end
          if (m_done) done_seen = 1'b1;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_write_count", wa.size(), 1);
        if (wa.size() > 0) begin
          chk("abort_wr_addr", wa[0], 0);
          chk("abort_wr_data", wd[0], mb[1]);
        end
        return;
      end
      if (m_done) begin done_at = cyc; break; end
    end
    chk("done_cycle", done_at, exp_busy);
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("ss_low_cycles", ss_cnt, exp_ss);
    chk("mosi_byte_count", got_b.size(), n + 1);
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      chk("mosi_byte", got_b[i], exp_b[i]);
    chk("rx_write_count", wa.size(), o ? n : 0);
    for (int k = 0; k < wa.size() && k < n; k++) begin
      chk("rx_addr", wa[k], k % (1 << aw));
      chk("rx_data", wd[k], mb[k + 1]);
    end
    if (n == (1 << aw)) chk("tx_addr_wrapped", m_ta, 0);
    if (!hold) begin
      @(posedge SysClk); @(negedge SysClk);
      chk("idle_after_done", m_busy, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tx_mem[i] = 8'($urandom);
    Reset = 1'b1;
    repeat (3) @(posedge SysClk);
    @(negedge SysClk);
    chk("rst_ss", m_ss, 1);
    chk("rst_clk", m_clk, 0);
    chk("rst_mosi", m_mosi, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_we", m_we, 0);
    chk("rst_rc_addr", m_ra, 0);
    chk("rst_rc_data", m_rd, 0);
    chk("rst_tx_addr", m_ta, 0);
    Reset = 1'b0;
    @(negedge SysClk);

    tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_mem[2] = 8'hFF;
    txn(0, 0, 0, 3, 0, 0);           // push, cont=0, three bytes
    txn(0, 0, 1, 0, 0, 0);           // push, cont=1, command only
    txn(0, 1, 0, 2, 0, 0);           // pull two bytes
    txn(0, 0, 0, 3, 1, 0);           // start held: second frame chains after done
    txn(0, 0, 0, 3, 0, 0);
    txn(0, 1, 0, 2, 0, 21);          // reset during bit 4 of payload byte 1
    txn(0, 0, 0, 2, 0, 0);           // push completes after the abort
    tx_mem[0] = 8'h81;
    txn(1, 0, 0, 1, 0, 0);           // ClkDiv=1, single byte
    txn(1, 0, 1, 4, 0, 0);           // full buffer, address wrap
    txn(1, 1, 0, 4, 0, 0);
    for (int r = 0; r < 4; r++)
      txn(0, 1'($urandom), 1'($urandom), $urandom_range(0, 5), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
